// File: rtl/mc_phase_sequencer.sv
// One-hot phase FSM (p0..p4) for the multi-cycle core, with memory-wait timeout, aborts and counters.
// Pulses are registered and land with the transition they accompany; stall freezes everything except cyc_cnt.
module mc_phase_sequencer #(
    parameter int CNT_W    = 32,
    parameter int WAIT_W   = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       irfunc,
    input  logic [4:0]       regimm,
    input  logic             error,
    input  logic             stall,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic [4:0]       p,
    output logic             insn_done,
    output logic             excp,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] cyc_cnt
);

    typedef enum logic [4:0] {
        P0 = 5'b00001,
        P1 = 5'b00010,
        P2 = 5'b00100,
        P3 = 5'b01000,
        P4 = 5'b10000
    } phase_t;

    typedef enum logic [2:0] {
        C_CALC, C_LOAD, C_STORE, C_BR, C_JUMP, C_ILL
    } cls_t;

    phase_t            state, state_nxt;
    cls_t              cls;
    logic              is_addsub;
    logic              mem_wait;
    logic [WAIT_W-1:0] wcnt, wcnt_nxt;
    logic              done_nxt, excp_nxt, ill_nxt, berr_nxt;

    // Instruction class decode; only meaningful once op is stable (p1 onward).
    always_comb begin
        cls       = C_ILL;
        is_addsub = 1'b0;
        case (op)
            6'h00: begin
                case (irfunc)
                    6'h20, 6'h22: begin
                        cls       = C_CALC;
                        is_addsub = 1'b1;
                    end
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: cls = C_CALC;
                    6'h08, 6'h09: cls = C_JUMP;
                    default: cls = C_ILL;
                endcase
            end
            6'h01: cls = (regimm == 5'd0 || regimm == 5'd1) ? C_BR : C_ILL;
            6'h02, 6'h03: cls = C_JUMP;
            6'h04, 6'h05, 6'h06, 6'h07: cls = C_BR;
            6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: cls = C_CALC;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: cls = C_LOAD;
            6'h28, 6'h29, 6'h2b: cls = C_STORE;
            default: cls = C_ILL;
        endcase
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        mem_wait  = 1'b0;
        done_nxt  = 1'b0;
        excp_nxt  = 1'b0;
        ill_nxt   = 1'b0;
        berr_nxt  = 1'b0;
        case (state)
            P0: begin
                mem_wait = 1'b1;
                if (mem_ready) state_nxt = P1;
            end
            P1: begin
                if (cls == C_ILL) begin
                    state_nxt = P0;
                    ill_nxt   = 1'b1;
                end else begin
                    state_nxt = P2;
                end
            end
            P2: begin
                case (cls)
                    C_BR: begin
                        state_nxt = P0;
                        done_nxt  = 1'b1;
                    end
                    C_LOAD, C_STORE: state_nxt = P3;
                    default: begin
                        if (is_addsub && error) begin
                            state_nxt = P0;
                            excp_nxt  = 1'b1;
                        end else begin
                            state_nxt = P4;
                        end
                    end
                endcase
            end
            P3: begin
                mem_wait = 1'b1;
                if (mem_ready) begin
                    if (cls == C_LOAD) begin
                        state_nxt = P4;
                    end else begin
                        state_nxt = P0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            P4: begin
                state_nxt = P0;
                done_nxt  = 1'b1;
            end
            default: state_nxt = P0;
        endcase

        // A timeout in p0 stays in p0, so the counter is cleared explicitly here.
        if (mem_wait && !mem_ready) begin
            if (wcnt == WAIT_W'(WAIT_MAX)) begin
                state_nxt = P0;
                berr_nxt  = 1'b1;
                wcnt_nxt  = '0;
            end else begin
                wcnt_nxt = wcnt + WAIT_W'(1);
            end
        end
        if (state_nxt != state) wcnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= P0;
            wcnt      <= '0;
            ret_cnt   <= '0;
            cyc_cnt   <= '0;
            insn_done <= 1'b0;
            excp      <= 1'b0;
            illegal   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (stall) begin
                insn_done <= 1'b0;
                excp      <= 1'b0;
                illegal   <= 1'b0;
                bus_err   <= 1'b0;
            end else begin
                state     <= state_nxt;
                wcnt      <= wcnt_nxt;
                insn_done <= done_nxt;
                excp      <= excp_nxt;
                illegal   <= ill_nxt;
                bus_err   <= berr_nxt;
                if (done_nxt) ret_cnt <= ret_cnt + CNT_W'(1);
            end
        end
    end

    assign p       = state;
    assign mem_req = state[0] | state[3];

endmodule

// File: tb/tb_mc_phase_sequencer.sv
// Directed bench for mc_phase_sequencer: per-cycle vector table plus hand-written wait/timeout/stall/reset sequences.
module tb_mc_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  irfunc;
    logic [4:0]  regimm;
    logic        error;
    logic        stall;
    logic        mem_ready;
    logic        mem_req;
    logic [4:0]  p;
    logic        insn_done, excp, illegal, bus_err;
    logic [31:0] ret_cnt, cyc_cnt;

    int checks = 0;
    int passes = 0;
    int ecyc   = 0;

    mc_phase_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .irfunc    (irfunc),
        .regimm    (regimm),
        .error     (error),
        .stall     (stall),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .p         (p),
        .insn_done (insn_done),
        .excp      (excp),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .ret_cnt   (ret_cnt),
        .cyc_cnt   (cyc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rt;
        logic        err;
        logic        mr;
        logic [4:0]  ep;
        logic        edone;
        logic        eexcp;
        logic        eill;
        logic [31:0] eret;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                       input logic e, input logic m, input logic [4:0] ep,
                       input logic d, input logic x, input logic il, input logic [31:0] rc);
        vec_t v;
        v.op = o; v.fn = f; v.rt = r; v.err = e; v.mr = m;
        v.ep = ep; v.edone = d; v.eexcp = x; v.eill = il; v.eret = rc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecyc++;
    endtask

    initial begin
        reset = 1'b1; op = '0; irfunc = '0; regimm = '0;
        error = 1'b0; stall = 1'b0; mem_ready = 1'b1;

        //   op     fn     rt  err mr  p      done excp ill ret
        add(6'h00, 6'h21, 5'd0, 0, 1, 5'h02, 0, 0, 0, 0);  // addu
        add(6'h00, 6'h21, 5'd0, 0, 1, 5'h04, 0, 0, 0, 0);
        add(6'h00, 6'h21, 5'd0, 0, 1, 5'h10, 0, 0, 0, 0);
        add(6'h00, 6'h21, 5'd0, 0, 1, 5'h01, 1, 0, 0, 1);
        add(6'h23, 6'h00, 5'd0, 0, 1, 5'h02, 0, 0, 0, 1);  // lw
        add(6'h23, 6'h00, 5'd0, 0, 1, 5'h04, 0, 0, 0, 1);
        add(6'h23, 6'h00, 5'd0, 0, 1, 5'h08, 0, 0, 0, 1);
        add(6'h23, 6'h00, 5'd0, 0, 1, 5'h10, 0, 0, 0, 1);
        add(6'h23, 6'h00, 5'd0, 0, 1, 5'h01, 1, 0, 0, 2);
        add(6'h00, 6'h20, 5'd0, 0, 1, 5'h02, 0, 0, 0, 2);  // add, overflow
        add(6'h00, 6'h20, 5'd0, 0, 1, 5'h04, 0, 0, 0, 2);
        add(6'h00, 6'h20, 5'd0, 1, 1, 5'h01, 0, 1, 0, 2);
        add(6'h00, 6'h21, 5'd0, 0, 1, 5'h02, 0, 0, 0, 2);  // addu, error ignored
        add(6'h00, 6'h21, 5'd0, 0, 1, 5'h04, 0, 0, 0, 2);
        add(6'h00, 6'h21, 5'd0, 1, 1, 5'h10, 0, 0, 0, 2);
        add(6'h00, 6'h21, 5'd0, 0, 1, 5'h01, 1, 0, 0, 3);
        add(6'h3f, 6'h00, 5'd0, 0, 1, 5'h02, 0, 0, 0, 3);  // illegal op
        add(6'h3f, 6'h00, 5'd0, 0, 1, 5'h01, 0, 0, 1, 3);
        add(6'h04, 6'h00, 5'd0, 0, 1, 5'h02, 0, 0, 0, 3);  // beq
        add(6'h04, 6'h00, 5'd0, 0, 1, 5'h04, 0, 0, 0, 3);
        add(6'h04, 6'h00, 5'd0, 0, 1, 5'h01, 1, 0, 0, 4);
        add(6'h01, 6'h00, 5'd1, 0, 1, 5'h02, 0, 0, 0, 4);  // bgez
        add(6'h01, 6'h00, 5'd1, 0, 1, 5'h04, 0, 0, 0, 4);
        add(6'h01, 6'h00, 5'd1, 0, 1, 5'h01, 1, 0, 0, 5);
        add(6'h01, 6'h00, 5'd2, 0, 1, 5'h02, 0, 0, 0, 5);  // regimm rt=2 is illegal
        add(6'h01, 6'h00, 5'd2, 0, 1, 5'h01, 0, 0, 1, 5);
        add(6'h02, 6'h00, 5'd0, 0, 1, 5'h02, 0, 0, 0, 5);  // j
        add(6'h02, 6'h00, 5'd0, 0, 1, 5'h04, 0, 0, 0, 5);
        add(6'h02, 6'h00, 5'd0, 0, 1, 5'h10, 0, 0, 0, 5);
        add(6'h02, 6'h00, 5'd0, 0, 1, 5'h01, 1, 0, 0, 6);
        add(6'h2b, 6'h00, 5'd0, 0, 1, 5'h02, 0, 0, 0, 6);  // sw
        add(6'h2b, 6'h00, 5'd0, 0, 1, 5'h04, 0, 0, 0, 6);
        add(6'h2b, 6'h00, 5'd0, 0, 1, 5'h08, 0, 0, 0, 6);
        add(6'h2b, 6'h00, 5'd0, 0, 1, 5'h01, 1, 0, 0, 7);

        // Reset state, sampled mid-cycle before release
        #12;
        chk("rst_p",       32'(p), 32'h01);
        chk("rst_mem_req", 32'(mem_req), 32'h1);
        chk("rst_ret",     ret_cnt, 32'd0);
        chk("rst_cyc",     cyc_cnt, 32'd0);
        chk("rst_pulses",  32'({insn_done, excp, illegal, bus_err}), 32'h0);
        reset = 1'b0;
        ecyc  = 0;

        foreach (vecs[i]) begin
            op = vecs[i].op; irfunc = vecs[i].fn; regimm = vecs[i].rt;
            error = vecs[i].err; mem_ready = vecs[i].mr;
            step();
            chk($sformatf("v%0d_p", i),       32'(p), 32'(vecs[i].ep));
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].ep == 5'h01 || vecs[i].ep == 5'h08));
            chk($sformatf("v%0d_done", i),    32'(insn_done), 32'(vecs[i].edone));
            chk($sformatf("v%0d_excp", i),    32'(excp), 32'(vecs[i].eexcp));
            chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].eill));
            chk($sformatf("v%0d_bus_err", i), 32'(bus_err), 32'h0);
            chk($sformatf("v%0d_ret", i),     ret_cnt, vecs[i].eret);
            chk($sformatf("v%0d_cyc", i),     cyc_cnt, 32'(ecyc));
        end
        error = 1'b0;

        // sw with mem_ready low for three cycles in p3
        op = 6'h2b; mem_ready = 1'b1;
        repeat (3) step();
        chk("sw_enter_p3", 32'(p), 32'h08);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("sw_hold%0d_p", k), 32'(p), 32'h08);
            chk($sformatf("sw_hold%0d_done", k), 32'(insn_done), 32'h0);
        end
        mem_ready = 1'b1;
        step();
        chk("sw_exit_p",    32'(p), 32'h01);
        chk("sw_exit_done", 32'(insn_done), 32'h1);
        chk("sw_exit_ret",  ret_cnt, 32'd8);

        // mem_ready stuck low in p0: timeout after 16 cycles
        mem_ready = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("to%0d_bus_err", k), 32'(bus_err), 32'h0);
            chk($sformatf("to%0d_p", k), 32'(p), 32'h01);
        end
        step();
        chk("to16_bus_err", 32'(bus_err), 32'h1);
        chk("to16_p",       32'(p), 32'h01);
        chk("to16_ret",     ret_cnt, 32'd8);
        step();
        chk("to17_bus_err", 32'(bus_err), 32'h0);

        // stall in p2 of lw: frozen for 5 cycles, cyc_cnt keeps counting
        op = 6'h23; mem_ready = 1'b1;
        repeat (2) step();
        chk("st_enter_p2", 32'(p), 32'h04);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("st%0d_p", k), 32'(p), 32'h04);
        end
        chk("st_cyc", cyc_cnt, 32'(ecyc));
        chk("st_ret", ret_cnt, 32'd8);
        stall = 1'b0;
        step();
        chk("st_release_p", 32'(p), 32'h08);

        // async reset asserted mid-p3
        #2 reset = 1'b1;
        #1;
        chk("ar_p",       32'(p), 32'h01);
        chk("ar_ret",     ret_cnt, 32'd0);
        chk("ar_cyc",     cyc_cnt, 32'd0);
        chk("ar_mem_req", 32'(mem_req), 32'h1);
        reset = 1'b0;
        ecyc  = 0;
        step();
        chk("ar_after_p",   32'(p), 32'h02);
        chk("ar_after_cyc", cyc_cnt, 32'(ecyc));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
